// File: rtl/pattern_scan_sched_if.sv
// Handshake/bus bundle for pattern_scan_sched.
// master: the requesting side (drives req/data, observes results).
// slave:  the scanner itself.
interface pattern_scan_sched_if #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
);
  logic              req0, req1;
  logic [WORD_W-1:0] data0, data1;
  logic              ack0, ack1;
  logic              busy;
  logic              grant;
  logic              bit_out;
  logic              detected;
  logic [CNT_W-1:0]  match_cnt;
  logic              done0, done1;

  modport master (
    output req0, req1, data0, data1,
    input  ack0, ack1, busy, grant, bit_out, detected, match_cnt, done0, done1
  );

  modport slave (
    input  req0, req1, data0, data1,
    output ack0, ack1, busy, grant, bit_out, detected, match_cnt, done0, done1
  );
endinterface

// File: rtl/pattern_scan_sched.sv
// Two-requester round-robin word scanner. Each granted word is shifted out
// MSB first through a "11" detector; matches are counted (saturating) and
// reported with a per-channel done pulse.
// Optional build macro SCAN_FLUSH_EN: reset the detector at the start of every
// word. Without it the detector carries state across word boundaries.
module pattern_scan_sched #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
) (
  input logic                  clk,
  input logic                  reset,
  pattern_scan_sched_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {NONE, ONE, ONES} det_t;

  localparam int BC_W = $clog2(WORD_W + 1);

  state_t            state;
  det_t              det;
  logic [WORD_W-1:0] sreg;
  logic [BC_W-1:0]   bcnt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, match_q;
  logic              grant_q, bit_q, busy_q;
  logic              ack0_q, ack1_q, done0_q, done1_q;
  logic              win, hit;
  logic [WORD_W-1:0] din;

  // Round-robin pick: on contention the channel not last served wins.
  always_comb begin
    win = bus.req1;
    if (bus.req0 && bus.req1) win = ~grant_q;
  end

  // Granted channel's word, sampled in LOAD.
  always_comb din = grant_q ? bus.data1 : bus.data0;

  // Mealy match and saturating next count.
  always_comb begin
    hit     = (state == SHIFT) && bit_q && (det != NONE);
    cnt_nxt = cnt;
    if (hit && (cnt != {CNT_W{1'b1}})) cnt_nxt = cnt + 1'b1;
  end

  // Scheduler FSM, shifter, detector and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      det     <= NONE;
      sreg    <= '0;
      bcnt    <= '0;
      cnt     <= '0;
      match_q <= '0;
      grant_q <= 1'b1;
      bit_q   <= 1'b0;
      busy_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            state   <= LOAD;
            busy_q  <= 1'b1;
            grant_q <= win;
            // ack is registered so it is high throughout the LOAD cycle
            ack0_q  <= ~win;
            ack1_q  <= win;
          end
        end
        LOAD: begin
          bit_q <= din[WORD_W-1];
          sreg  <= {din[WORD_W-2:0], 1'b0};
          cnt   <= '0;
          bcnt  <= '0;
`ifdef SCAN_FLUSH_EN
          det   <= NONE;
`endif
          state <= SHIFT;
        end
        SHIFT: begin
          if (!bit_q)           det <= NONE;
          else if (det == NONE) det <= ONE;
          else                  det <= ONES;
          cnt  <= cnt_nxt;
          bcnt <= bcnt + 1'b1;
          if (bcnt == BC_W'(WORD_W - 1)) begin
            // Last bit: publish the result so it is valid alongside done.
            state   <= DONE;
            bit_q   <= 1'b0;
            match_q <= cnt_nxt;
            done0_q <= ~grant_q;
            done1_q <= grant_q;
          end else begin
            bit_q <= sreg[WORD_W-1];
            sreg  <= {sreg[WORD_W-2:0], 1'b0};
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.busy      = busy_q;
  assign bus.grant     = grant_q;
  assign bus.bit_out   = bit_q;
  assign bus.detected  = hit;
  assign bus.match_cnt = match_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
endmodule

// File: tb/tb_pattern_scan_sched.sv
// Directed bench for pattern_scan_sched (default build and, via a second
// instance, CNT_W=2 saturation).
module tb_pattern_scan_sched;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pattern_scan_sched_if #(.WORD_W(8), .CNT_W(4)) bus ();
  pattern_scan_sched_if #(.WORD_W(8), .CNT_W(2)) bus2 ();

  pattern_scan_sched #(.WORD_W(8), .CNT_W(4)) u_dut (.clk(clk), .reset(reset), .bus(bus));
  pattern_scan_sched #(.WORD_W(8), .CNT_W(2)) u_sat (.clk(clk), .reset(reset), .bus(bus2));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();
  endtask

  // One single-requester word, checking ack, every shift cycle, done and count.
  task automatic scan_word(input bit ch, input logic [7:0] d, input logic [7:0] exp_det,
                           input int exp_cnt, input string tag);
    if (ch) begin bus.req1 = 1'b1; bus.data1 = d; end
    else    begin bus.req0 = 1'b1; bus.data0 = d; end
    tick();
    chk({tag, " ack"}, ch ? bus.ack1 : bus.ack0, 1);
    chk({tag, " other ack"}, ch ? bus.ack0 : bus.ack1, 0);
    chk({tag, " grant"}, bus.grant, ch);
    chk({tag, " busy"}, bus.busy, 1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick();
    // scramble inputs mid-word: must not disturb the word in flight
    bus.data0 = ~d;
    bus.data1 = ~d;
    for (int k = 0; k < 8; k++) begin
      chk({tag, " bit_out"}, bus.bit_out, d[7-k]);
      chk({tag, " detected"}, bus.detected, exp_det[7-k]);
      if (k < 7) tick();
    end
    tick();
    chk({tag, " done"}, ch ? bus.done1 : bus.done0, 1);
    chk({tag, " other done"}, ch ? bus.done0 : bus.done1, 0);
    chk({tag, " match_cnt"}, bus.match_cnt, exp_cnt);
    chk({tag, " detected in DONE"}, bus.detected, 0);
    tick();
    chk({tag, " idle busy"}, bus.busy, 0);
    chk({tag, " done clears"}, bus.done0 | bus.done1, 0);
    chk({tag, " match held"}, bus.match_cnt, exp_cnt);
  endtask

  initial begin
    int a0, a1, d0, d1, g0, g1;
    bit saw_done;
    bus.req0 = 0; bus.req1 = 0; bus.data0 = '0; bus.data1 = '0;
    bus2.req0 = 0; bus2.req1 = 0; bus2.data0 = '0; bus2.data1 = '0;

    // Reset state
    do_reset();
    chk("rst busy", bus.busy, 0);
    chk("rst grant", bus.grant, 1);
    chk("rst match_cnt", bus.match_cnt, 0);
    chk("rst acks", {bus.ack0, bus.ack1}, 0);
    chk("rst dones", {bus.done0, bus.done1}, 0);
    chk("rst bit_out", bus.bit_out, 0);
    chk("rst detected", bus.detected, 0);

    // 0xFF on ch0: matches on shift cycles 2..8
    scan_word(1'b0, 8'hFF, 8'h7F, 7, "ff");

    // 0xB6 on ch1 from a clean detector: matches on cycles 4 and 7
    do_reset();
    scan_word(1'b1, 8'hB6, 8'h12, 2, "b6");

    // Both requesting after reset: ch0 first, ch1 one word later
    do_reset();
    a0 = -1; a1 = -1; d0 = -1; d1 = -1; g0 = -1; g1 = -1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      tick();
      if (bus.ack0) begin a0 = cyc; g0 = int'(bus.grant); bus.req0 = 1'b0; end
      if (bus.ack1) begin a1 = cyc; g1 = int'(bus.grant); bus.req1 = 1'b0; end
      if (bus.done0) d0 = cyc;
      if (bus.done1) d1 = cyc;
    end
    chk("rr ack0 cycle", a0, 1);
    chk("rr grant at ack0", g0, 0);
    chk("rr done0 cycle", d0, 10);
    chk("rr ack1 cycle", a1, 12);
    chk("rr grant at ack1", g1, 1);
    chk("rr done1-done0", d1 - d0, 11);

    // 0x01 then 0x80 on ch0: detector carry-over across the word boundary
    do_reset();
    scan_word(1'b0, 8'h01, 8'h00, 0, "w01");
`ifdef SCAN_FLUSH_EN
    scan_word(1'b0, 8'h80, 8'h00, 0, "w80");
`else
    scan_word(1'b0, 8'h80, 8'h80, 1, "w80");
`endif

    // CNT_W=2 instance: seven matches saturate at 3
    do_reset();
    bus2.req0 = 1'b1; bus2.data0 = 8'hFF;
    tick();
    chk("sat ack0", bus2.ack0, 1);
    bus2.req0 = 1'b0;
    repeat (8) tick();
    tick();
    chk("sat done0", bus2.done0, 1);
    chk("sat match_cnt", bus2.match_cnt, 3);

    // Reset in the 3rd shift cycle discards the word
    do_reset();
    bus.req1 = 1'b1; bus.data1 = 8'hFF;
    tick();
    chk("abort ack1", bus.ack1, 1);
    bus.req1 = 1'b0;
    repeat (3) tick();
    chk("abort in shift", bus.busy, 1);
    reset = 1'b1;
    #1;
    chk("abort busy", bus.busy, 0);
    chk("abort detected", bus.detected, 0);
    chk("abort bit_out", bus.bit_out, 0);
    chk("abort grant", bus.grant, 1);
    #1 reset = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      tick();
      if (bus.done0 || bus.done1) saw_done = 1'b1;
    end
    chk("abort no done", saw_done, 0);
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.data0 = 8'hFF;
    tick();
    chk("after abort ack0", bus.ack0, 1);
    chk("after abort ack1", bus.ack1, 0);
    chk("after abort grant", bus.grant, 0);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (8) tick();
    tick();
    chk("after abort done0", bus.done0, 1);
    chk("after abort match_cnt", bus.match_cnt, 7);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pattern_scan_sched.md
PATTERN_SCAN_SCHED -- requirements
Module: pattern_scan_sched

Interface
REQ-001 The block SHALL have parameter WORD_W, default 8: bits per scanned word, MSB first.
REQ-002 The block SHALL have parameter CNT_W, default 4: width of the saturating match counter.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have ports req0/req1  input  1 each  requester 0/1 has a word pending; held until its ack.
REQ-006 The block SHALL have ports data0/data1  input  WORD_W each  word of requester 0/1; stable while its req is high.
REQ-007 The block SHALL have ports ack0/ack1  output  1 each  one-cycle pulse: word captured from requester 0/1.
REQ-008 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 The block SHALL have port grant  output  1  channel currently or last served (0 or 1).
REQ-010 The block SHALL have port bit_out  output  1  bit presented to the internal "11" detector this cycle.
REQ-011 The block SHALL have port detected  output  1  Mealy match strobe: bit_out and the previous shifted bit are both 1.
REQ-012 The block SHALL have port match_cnt  output  CNT_W  matches in the last completed word; held until the next DONE.
REQ-013 The block SHALL have ports done0/done1  output  1 each  one-cycle pulse: word of requester 0/1 finished; match_cnt valid.

Function
REQ-014 The block SHALL implement the FSM states IDLE, LOAD, SHIFT and DONE.
REQ-015 IDLE SHALL go to LOAD when req0 or req1 is high, otherwise stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: with both req high, the channel not equal to grant wins; with one req high, that channel wins.
REQ-017 grant SHALL update on the IDLE->LOAD edge and stay stable until the next grant.
REQ-018 In LOAD the block SHALL capture data of the granted channel into a shift register, pulse that channel's ack for exactly one cycle, clear the working counter, and go to SHIFT.
REQ-019 SHIFT SHALL last exactly WORD_W cycles, present register bits MSB first on bit_out, and step the detector state (NONE, ONE, ONES) once per cycle.
REQ-020 Detector transitions SHALL be: bit 0 -> NONE; bit 1 from NONE -> ONE; bit 1 from ONE or ONES -> ONES with detected=1.
REQ-021 detected SHALL be 0 outside SHIFT.
REQ-022 The working counter SHALL increment once per detected cycle and saturate at 2^CNT_W-1 without wrapping.
REQ-023 DONE SHALL last one cycle: load match_cnt from the working counter, pulse done of the granted channel, and return to IDLE.
REQ-024 Per-word latency SHALL be: ack at cycle t+1 after req is sampled in IDLE at t, done at t+WORD_W+2; the next grant is possible at t+WORD_W+3.
REQ-025 req remaining high after ack SHALL be treated as a new request in the next IDLE.
REQ-026 req dropping before ack SHALL withdraw the request with no ack and no done.
REQ-027 Changes on data or req during SHIFT or DONE SHALL have no effect on the word in flight.

Reset
REQ-028 Asserting reset SHALL immediately return the FSM to IDLE and the detector to NONE.
REQ-029 Reset SHALL clear the shift register and the working counter, and set match_cnt=0, grant=1 (so channel 0 is served first), and ack0, ack1, done0, done1, busy, bit_out and detected to 0.
REQ-030 Reset during LOAD, SHIFT or DONE SHALL discard the word in flight and produce no done pulse.

Configuration
REQ-031 With macro SCAN_FLUSH_EN defined, the detector SHALL return to NONE in every LOAD, so each word is scanned independently.
REQ-032 Without SCAN_FLUSH_EN, detector state SHALL carry over from the last bit of the previous word, regardless of channel.

Verification
REQ-033 The bench SHALL cover: reset, then req0=1 with data0=0xFF (flush on) -> ack0 at t+1, done0 at t+10, match_cnt=7.
REQ-034 The bench SHALL cover: req0 and req1 high together after reset -> ch0 served first, then ch1; grant 0 then 1; done0 precedes done1 by 11 cycles.
REQ-035 The bench SHALL cover: data1=0xB6 (10110110), single request -> detected high on the 4th and 7th shift cycles, match_cnt=2.
REQ-036 The bench SHALL cover: flush off, word 0x01 then word 0x80 on ch0 -> second word match_cnt=1; with flush on -> match_cnt=0.
REQ-037 The bench SHALL cover: CNT_W=2, data=0xFF -> match_cnt saturates at 3.
REQ-038 The bench SHALL cover: reset pulsed in the 3rd SHIFT cycle -> busy=0 at once, no done pulse, next request is served normally with grant resolving to ch0.
